// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: the operands are split into STAGES slices,
// one registered CLA slice per stage, with a single global stall enable for backpressure.
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             Clk_i,
    input  logic             Reset_n_i,
    input  logic             Valid_i,
    output logic             Ready_o,
    input  logic [WIDTH-1:0] Number1_i,
    input  logic [WIDTH-1:0] Number2_i,
    input  logic             Carry_i,
    input  logic             Sub_i,
    output logic             Valid_o,
    input  logic             Ready_i,
    output logic [WIDTH-1:0] Result_o,
    output logic             Carry_o,
    output logic             Overflow_o,
    output logic             Zero_o
);
    localparam int SW = WIDTH / STAGES;

    // Each carry is a flat sum of generate terms plus the all-propagate
    // term, so no carry depends on a lower carry of the same slice.
    function automatic logic [SW:0] cla_add(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b,
        input logic          cin
    );
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW:0]   c;
        logic          all_p;
        logic          any_g;
        logic          chain;
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        c[0]  = cin;
        all_p = 1'b0;
        any_g = 1'b0;
        chain = 1'b0;
        for (int i = 0; i < SW; i++) begin
            all_p = cin;
            any_g = 1'b0;
            for (int j = 0; j <= i; j++) begin
                all_p = all_p & p[j];
                chain = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    chain = chain & p[m];
                end
                any_g = any_g | chain;
            end
            c[i+1] = any_g | all_p;
        end
        return {c[SW], p ^ c[SW-1:0]};
    endfunction

    logic w_en;

    // The pipe only freezes while a finished result is waiting on downstream.
    assign w_en    = Ready_i || !Valid_o;
    assign Ready_o = w_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_res_in;
        logic [WIDTH-1:0] w_res;
        logic             w_sub;
        logic             w_cin;
        logic             w_amsb;
        logic             w_bmsb;
        logic             w_vld;
        logic [SW:0]      w_sum;

        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH-1:0] r_res;
        logic             r_sub;
        logic             r_cy;
        logic             r_amsb;
        logic             r_bmsb;
        logic             r_vld;

        if (k == 0) begin : g_in
            // Subtract is A + ~B + 1 - borrow, so the borrow-in maps to an inverted carry-in.
            assign w_a      = Number1_i;
            assign w_b      = Number2_i;
            assign w_sub    = Sub_i;
            assign w_cin    = Carry_i ^ Sub_i;
            assign w_amsb   = Number1_i[WIDTH-1];
            assign w_bmsb   = Number2_i[WIDTH-1] ^ Sub_i;
            assign w_res_in = '0;
            assign w_vld    = Valid_i && w_en;
        end else begin : g_fwd
            assign w_a      = g_stage[k-1].r_a;
            assign w_b      = g_stage[k-1].r_b;
            assign w_sub    = g_stage[k-1].r_sub;
            assign w_cin    = g_stage[k-1].r_cy;
            assign w_amsb   = g_stage[k-1].r_amsb;
            assign w_bmsb   = g_stage[k-1].r_bmsb;
            assign w_res_in = g_stage[k-1].r_res;
            assign w_vld    = g_stage[k-1].r_vld;
        end

        // Operands travel right-shifted so every stage adds bits [SW-1:0].
        assign w_sum = cla_add(w_a[SW-1:0], w_b[SW-1:0] ^ {SW{w_sub}}, w_cin);

        always_comb begin
            w_res                = w_res_in;
            w_res[k*SW +: SW]    = w_sum[SW-1:0];
        end

        always_ff @(posedge Clk_i) begin
            if (!Reset_n_i) begin
                r_a    <= '0;
                r_b    <= '0;
                r_res  <= '0;
                r_sub  <= 1'b0;
                r_cy   <= 1'b0;
                r_amsb <= 1'b0;
                r_bmsb <= 1'b0;
                r_vld  <= 1'b0;
            end else if (w_en) begin
                r_a    <= w_a >> SW;
                r_b    <= w_b >> SW;
                r_res  <= w_res;
                r_sub  <= w_sub;
                r_cy   <= w_sum[SW];
                r_amsb <= w_amsb;
                r_bmsb <= w_bmsb;
                r_vld  <= w_vld;
            end
        end

        if (k == STAGES - 1) begin : g_tail
            logic w_unused_tail;
            assign w_unused_tail = ^{r_a, r_b, r_sub};
        end
    end

    assign Valid_o    = g_stage[STAGES-1].r_vld;
    assign Result_o   = g_stage[STAGES-1].r_res;
    assign Carry_o    = g_stage[STAGES-1].r_cy;
    assign Overflow_o = (g_stage[STAGES-1].r_amsb == g_stage[STAGES-1].r_bmsb) &&
                        (Result_o[WIDTH-1] != g_stage[STAGES-1].r_amsb);
    assign Zero_o     = (Result_o == '0);

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: a 4-stage and a 1-stage instance share one input stream
// and are each scored against a signed/unsigned arithmetic reference model.
module tb_cla_addsub_pipe;
    localparam int W = 32;
    localparam int S = 4;

    typedef logic [W+2:0] exp_t;  // {carry, overflow, zero, result}

    logic         clk = 1'b0;
    logic         rst_n;
    logic         vld_i;
    logic         cin;
    logic         sub;
    logic         rdy_i;
    logic         rdy_i1;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         rdy_o, vld_o, co, ov, zo;
    logic [W-1:0] res;
    logic         rdy_o1, vld_o1, co1, ov1, zo1;
    logic [W-1:0] res1;

    exp_t exp_q[$];
    exp_t exp1_q[$];
    int   acc_q[$];
    int   acc1_q[$];
    exp_t cur_exp;

    int n_cmp      = 0;
    int n_bad      = 0;
    int cyc        = 0;
    int popped     = 0;
    int stall_left = 0;
    bit lat_on     = 1'b1;
    bit bp_mode    = 1'b0;
    bit rand_rdy   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_addsub_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
        .Clk_i(clk), .Reset_n_i(rst_n), .Valid_i(vld_i), .Ready_o(rdy_o),
        .Number1_i(a), .Number2_i(b), .Carry_i(cin), .Sub_i(sub),
        .Valid_o(vld_o), .Ready_i(rdy_i), .Result_o(res), .Carry_o(co),
        .Overflow_o(ov), .Zero_o(zo)
    );

    cla_addsub_pipe #(.WIDTH(W), .STAGES(1)) u_dut1 (
        .Clk_i(clk), .Reset_n_i(rst_n), .Valid_i(vld_i), .Ready_o(rdy_o1),
        .Number1_i(a), .Number2_i(b), .Carry_i(cin), .Sub_i(sub),
        .Valid_o(vld_o1), .Ready_i(rdy_i1), .Result_o(res1), .Carry_o(co1),
        .Overflow_o(ov1), .Zero_o(zo1)
    );

    // Reference: plain signed arithmetic for overflow, unsigned compare for carry/borrow.
    function automatic exp_t ref_op(logic [W-1:0] av, logic [W-1:0] bv, logic ci, logic sb);
        longint sa, sbv, c, s;
        logic [63:0] su;
        logic [63:0] ua, ub;
        logic carry, ovf;
        sa  = $signed(av);
        sbv = $signed(bv);
        c   = ci;
        ua  = {32'b0, av};
        ub  = {32'b0, bv};
        if (!sb) begin
            s     = sa + sbv + c;
            carry = (ua + ub + 64'(ci)) >= 64'h1_0000_0000;
        end else begin
            s     = sa - sbv - c;
            carry = ua >= (ub + 64'(ci));
        end
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        su  = s;
        return {carry, ovf, (su[W-1:0] == '0), su[W-1:0]};
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_ready();
        if (stall_left > 0) begin
            rdy_i = 1'b0;
            stall_left--;
        end else if (rand_rdy) begin
            rdy_i = ($urandom_range(0, 3) != 0);
        end else begin
            rdy_i = 1'b1;
        end
        rdy_i1 = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    endtask

    // Scoreboard: evaluated once per cycle, after inputs settle and before the next edge.
    task automatic monitor();
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            exp1_q.delete();
            acc1_q.delete();
            return;
        end
        check("ready_o_s4", rdy_o, rdy_i || !vld_o);
        check("ready_o_s1", rdy_o1, rdy_i1 || !vld_o1);
        if (vld_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid_s4", vld_o, 1'b0);
            end else begin
                check("result_s4", {co, ov, zo, res}, exp_q[0]);
                if (rdy_i) begin
                    if (lat_on) check("latency_s4", cyc - acc_q[0], S);
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    popped++;
                    if (bp_mode && popped == 2) stall_left = 3;
                end
            end
        end
        if (vld_o1) begin
            if (exp1_q.size() == 0) begin
                check("spurious_valid_s1", vld_o1, 1'b0);
            end else begin
                check("result_s1", {co1, ov1, zo1, res1}, exp1_q[0]);
                if (rdy_i1) begin
                    if (lat_on) check("latency_s1", cyc - acc1_q[0], 1);
                    void'(exp1_q.pop_front());
                    void'(acc1_q.pop_front());
                end
            end
        end
        if (vld_i && rdy_o) begin
            exp_q.push_back(cur_exp);
            acc_q.push_back(cyc);
        end
        if (vld_i && rdy_o1) begin
            exp1_q.push_back(cur_exp);
            acc1_q.push_back(cyc);
        end
    endtask

    task automatic send(logic [W-1:0] av, logic [W-1:0] bv, logic ci, logic sb, exp_t e);
        int  guard;
        bit  acc;
        guard = 0;
        acc   = 1'b0;
        do begin
            @(negedge clk);
            set_ready();
            a = av; b = bv; cin = ci; sub = sb; vld_i = 1'b1; cur_exp = e;
            #1;
            acc = rdy_o;
            monitor();
            guard++;
        end while (!acc && guard < 200);
        check("send_accepted", acc, 1'b1);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            set_ready();
            vld_i = 1'b0;
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            #1;
            monitor();
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() + exp1_q.size()) != 0 && g < 300) begin
            idle(1);
            g++;
        end
        check("drain_empty", exp_q.size() + exp1_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vld_i = 1'b1;
        a = 32'd15; b = 32'd25; cin = 1'b0; sub = 1'b0;
        #1;
        monitor();
        @(negedge clk);
        rst_n = 1'b1;
        vld_i = 1'b0;
        set_ready();
        #1;
        check("rst_valid_s4", vld_o, 1'b0);
        check("rst_result_s4", res, '0);
        check("rst_zero_s4", zo, 1'b1);
        check("rst_carry_s4", co, 1'b0);
        check("rst_ovf_s4", ov, 1'b0);
        check("rst_valid_s1", vld_o1, 1'b0);
        check("rst_result_s1", res1, '0);
        check("rst_zero_s1", zo1, 1'b1);
        monitor();
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sb;
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } vec_t;

    vec_t dir_tab[6] = '{
        '{32'd15,        32'd25,        1'b0, 1'b0, 32'd40,        1'b0, 1'b0},
        '{32'hFFFFFFFF,  32'h00000001,  1'b0, 1'b0, 32'h00000000,  1'b1, 1'b0},
        '{32'h7FFFFFFF,  32'h00000001,  1'b0, 1'b0, 32'h80000000,  1'b0, 1'b1},
        '{32'h80000000,  32'h00000001,  1'b0, 1'b1, 32'h7FFFFFFF,  1'b1, 1'b1},
        '{32'd100,       32'd200,       1'b0, 1'b1, 32'hFFFFFF9C,  1'b0, 1'b0},
        '{32'd4345,      32'd567,       1'b1, 1'b1, 32'd3777,      1'b1, 1'b0}
    };

    vec_t bp_tab[8] = '{
        '{32'd986,  32'd3476,  1'b1, 1'b0, 32'd4463,  1'b0, 1'b0},
        '{32'd4345, 32'd567,   1'b0, 1'b0, 32'd4912,  1'b0, 1'b0},
        '{32'd454,  32'd134,   1'b1, 1'b0, 32'd589,   1'b0, 1'b0},
        '{32'd537,  32'd7956,  1'b0, 1'b0, 32'd8493,  1'b0, 1'b0},
        '{32'd3013, 32'd597,   1'b1, 1'b0, 32'd3611,  1'b0, 1'b0},
        '{32'd7896, 32'd52,    1'b0, 1'b0, 32'd7948,  1'b0, 1'b0},
        '{32'd3167, 32'd13467, 1'b1, 1'b0, 32'd16635, 1'b0, 1'b0},
        '{32'd15,   32'd25,    1'b0, 1'b0, 32'd40,    1'b0, 1'b0}
    };

    function automatic exp_t tab_exp(vec_t v);
        return {v.c, v.v, (v.r == '0), v.r};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners[4];
        corners[0] = '0;
        corners[1] = '1;
        corners[2] = 32'h80000000;
        corners[3] = 32'h7FFFFFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    task automatic random_ops(int n);
        logic [W-1:0] av, bv;
        logic ci, sb;
        for (int i = 0; i < n; i++) begin
            av = pick_operand();
            bv = pick_operand();
            ci = 1'($urandom);
            sb = 1'($urandom);
            send(av, bv, ci, sb, ref_op(av, bv, ci, sb));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b0; vld_i = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        rdy_i = 1'b1; rdy_i1 = 1'b1; cur_exp = '0;
        do_reset();
        idle(2);

        // Directed corner cases, back to back, exact latency checked.
        foreach (dir_tab[i]) send(dir_tab[i].a, dir_tab[i].b, dir_tab[i].ci, dir_tab[i].sb, tab_exp(dir_tab[i]));
        drain();

        // Backpressure: Ready_i drops for 3 cycles after the 2nd result.
        lat_on  = 1'b0;
        bp_mode = 1'b1;
        popped  = 0;
        foreach (bp_tab[i]) send(bp_tab[i].a, bp_tab[i].b, bp_tab[i].ci, bp_tab[i].sb, tab_exp(bp_tab[i]));
        drain();
        check("bp_result_count", popped, 8);
        bp_mode = 1'b0;
        lat_on  = 1'b1;

        // Reset with three operations in flight; nothing stale may emerge afterwards.
        for (int i = 0; i < 3; i++) send(bp_tab[i].a, bp_tab[i].b, bp_tab[i].ci, bp_tab[i].sb, tab_exp(bp_tab[i]));
        do_reset();
        idle(8);
        send(32'd15, 32'd25, 1'b0, 1'b0, ref_op(32'd15, 32'd25, 1'b0, 1'b0));
        drain();

        // Random stream with bubbles, always-ready sink: latency still exact.
        random_ops(60);

        // Random stream with random backpressure on both instances.
        lat_on   = 1'b0;
        rand_rdy = 1'b1;
        random_ops(250);
        rand_rdy = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
